// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT word width, default modulus and Barrett constant helper
package ntt_pkg;

    localparam int unsigned WORD_W = 30;

    // 2^30 - 2^18 + 1, NTT-friendly prime in (2^29, 2^30)
    localparam logic [WORD_W-1:0] Q_DEFAULT = 30'd1073479681;

    // floor(2^60 / q); fits in 31 bits because q > 2^29
    function automatic logic [30:0] barrett_mu(input logic [63:0] q);
        return 31'((64'd1 << 60) / q);
    endfunction

endpackage

// File: rtl/barrett_final_correction.sv
// rtl/barrett_final_correction.sv - combinational reduction of r in [0, 3Q) to [0, Q)
// Ports:
//   r  in  32  partially reduced value, 0 <= r < 3Q
//   c  out 30  r mod Q
module barrett_final_correction
    import ntt_pkg::*;
#(
    parameter logic [WORD_W-1:0] Q = Q_DEFAULT
) (
    input  logic [31:0]       r,
    output logic [WORD_W-1:0] c
);

    localparam logic [31:0] Q1 = 32'(Q);
    localparam logic [31:0] Q2 = 32'(Q) << 1;

    logic [31:0] diff;
    logic [1:0]  unused_diff_hi;

    // Both compares run in parallel; a single subtract selects the offset.
    always_comb begin
        diff = r;
        if (r >= Q2) begin
            diff = r - Q2;
        end else if (r >= Q1) begin
            diff = r - Q1;
        end
    end

    // Result is < Q < 2^30, so the top two bits are always zero.
    assign c              = diff[WORD_W-1:0];
    assign unused_diff_hi = diff[31:WORD_W];

endmodule

// File: rtl/barrett_modular_multiplier.sv
// rtl/barrett_modular_multiplier.sv - 5-stage pipelined Barrett (a*b) mod Q with valid/tag
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset, clears all stages, overrides en
//   en         in   1      pipeline advance; 0 freezes every register
//   in_valid   in   1      a, b, in_tag valid this cycle
//   a          in   30     operand, < Q
//   b          in   30     twiddle, < Q
//   in_tag     in   TAG_W  opaque tag
//   out_valid  out  1      c, out_tag valid
//   c          out  30     (a*b) mod Q
//   out_tag    out  TAG_W  tag delayed with its data
module barrett_modular_multiplier
    import ntt_pkg::*;
#(
    parameter logic [WORD_W-1:0] Q     = Q_DEFAULT,
    parameter int unsigned       TAG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [WORD_W-1:0] c,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned N_STAGES = 5;
    localparam logic [30:0] MU       = barrett_mu(64'(Q));

    // S1
    logic [59:0]       p1_q, p1_d;
    // S2: only the quotient estimate m2[61:31] is ever consumed downstream
    logic [30:0]       m2_hi_q, m2_hi_d;
    logic [31:0]       x2_q, x2_d;
    // S3
    logic [31:0]       qq3_q, qq3_d;
    logic [31:0]       x3_q, x3_d;
    // S4
    logic [31:0]       r4_q, r4_d;
    // S5
    logic [WORD_W-1:0] c_q, c_d;

    logic [N_STAGES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [N_STAGES];
    logic [TAG_W-1:0]    tag_d [N_STAGES];

    logic [61:0]       m2_full;
    logic [61:0]       qq3_full;
    logic [WORD_W-1:0] corr_c;
    logic              unused_prod_bits;

    barrett_final_correction #(
        .Q (Q)
    ) u_final_correction (
        .r (r4_q),
        .c (corr_c)
    );

    always_comb begin
        m2_full  = 62'(p1_q[59:29]) * 62'(MU);
        qq3_full = 62'(m2_hi_q) * 62'(Q);

        p1_d    = p1_q;
        m2_hi_d = m2_hi_q;
        x2_d    = x2_q;
        qq3_d   = qq3_q;
        x3_d    = x3_q;
        r4_d    = r4_q;
        c_d     = c_q;
        valid_d = valid_q;
        tag_d   = tag_q;

        if (rst) begin
            p1_d    = '0;
            m2_hi_d = '0;
            x2_d    = '0;
            qq3_d   = '0;
            x3_d    = '0;
            r4_d    = '0;
            c_d     = '0;
            valid_d = '0;
            for (int i = 0; i < N_STAGES; i++) begin
                tag_d[i] = '0;
            end
        end else if (en) begin
            // Data stages load unconditionally; the valid bit alone marks meaning.
            p1_d    = 60'(a) * 60'(b);
            m2_hi_d = m2_full[61:31];
            x2_d    = p1_q[31:0];
            // Only the low 32 bits matter: the true remainder is < 3Q < 2^32,
            // so arithmetic mod 2^32 recovers it exactly.
            qq3_d   = qq3_full[31:0];
            x3_d    = x2_q;
            r4_d    = x3_q - qq3_q;
            c_d     = corr_c;
            valid_d = {valid_q[N_STAGES-2:0], in_valid};
            tag_d[0] = in_tag;
            for (int i = 1; i < N_STAGES; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        p1_q    <= p1_d;
        m2_hi_q <= m2_hi_d;
        x2_q    <= x2_d;
        qq3_q   <= qq3_d;
        x3_q    <= x3_d;
        r4_q    <= r4_d;
        c_q     <= c_d;
        valid_q <= valid_d;
        tag_q   <= tag_d;
    end

    assign unused_prod_bits = ^{m2_full[30:0], qq3_full[61:32]};

    assign out_valid = valid_q[N_STAGES-1];
    assign c         = c_q;
    assign out_tag   = tag_q[N_STAGES-1];

endmodule

// File: tb/tb_barrett_modular_multiplier.sv
// tb/tb_barrett_modular_multiplier.sv - randomized scoreboard bench for barrett_modular_multiplier
module tb_barrett_modular_multiplier;

    localparam logic [29:0] QV = 30'd1073479681;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [29:0] a;
    logic [29:0] b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic [29:0] c;
    logic [7:0]  out_tag;

    barrett_modular_multiplier #(
        .Q     (QV),
        .TAG_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .c         (c),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned edge_no;
        logic [7:0]  tag;
        logic [29:0] res;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_cnt;
    int          n_checks;
    int          n_errors;
    logic        last_v;
    logic [29:0] last_c;
    logic [7:0]  last_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [29:0] mod_mul(input logic [29:0] x, input logic [29:0] y);
        longint unsigned px, py, pq;
        px = 64'(x);
        py = 64'(y);
        pq = 64'(QV);
        return 30'((px * py) % pq);
    endfunction

    // Result for the pair accepted on enabled edge N is due right after enabled edge N+4.
    task automatic cycle(input logic r, input logic e, input logic v,
                         input logic [29:0] aa, input logic [29:0] bb, input logic [7:0] tg);
        logic ev;
        exp_t item;
        rst = r; en = e; in_valid = v; a = aa; b = bb; in_tag = tg;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            last_v = 1'b0; last_c = '0; last_tag = '0;
        end else if (e) begin
            edge_cnt++;
            if (v) exp_q.push_back('{edge_cnt, tg, mod_mul(aa, bb)});
        end
        #1;
        if (r) begin
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_c", 64'(c), 64'd0);
            check("reset_out_tag", 64'(out_tag), 64'd0);
        end else if (e) begin
            ev = (exp_q.size() > 0) && (exp_q[0].edge_no + 4 == edge_cnt);
            check("out_valid", 64'(out_valid), 64'(ev));
            if (ev) begin
                item = exp_q.pop_front();
                check("c", 64'(c), 64'(item.res));
                check("out_tag", 64'(out_tag), 64'(item.tag));
                check("c_lt_q", 64'(c < QV), 64'd1);
                last_c = item.res; last_tag = item.tag;
            end
            last_v = ev;
        end else begin
            check("stall_out_valid", 64'(out_valid), 64'(last_v));
            if (last_v) begin
                check("stall_c", 64'(c), 64'(last_c));
                check("stall_out_tag", 64'(out_tag), 64'(last_tag));
            end
        end
    endtask

    function automatic logic [29:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return QV - 30'($urandom_range(1, 64));
            1:       return 30'd536870912 + 30'($urandom_range(0, 64)) - 30'd32;
            2:       return 30'($urandom_range(0, 64));
            default: return 30'($urandom_range(0, 32'd1073479680));
        endcase
    endfunction

    task automatic drain();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; edge_cnt = 0;
        last_v = 1'b0; last_c = '0; last_tag = '0;

        cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);

        // Directed cases
        cycle(1'b0, 1'b1, 1'b1, 30'd1, 30'd1, 8'h5A);
        drain();
        check("identity_seen", 64'(exp_q.size()), 64'd0);
        cycle(1'b0, 1'b1, 1'b1, QV - 30'd1, QV - 30'd1, 8'h01);
        cycle(1'b0, 1'b1, 1'b1, 30'd0, QV - 30'd1, 8'h02);
        cycle(1'b0, 1'b1, 1'b1, 30'd2, 30'd536739841, 8'h03);
        drain();
        check("directed_seen", 64'(exp_q.size()), 64'd0);

        // Streaming with random bubbles
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 3) != 0),
                  rand_operand(), rand_operand(), 8'($urandom));
        end
        drain();
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Streaming with random stalls
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                  rand_operand(), rand_operand(), 8'($urandom));
        end
        drain();
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream with four valids in flight; reset must win over en=0
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b1, rand_operand(), rand_operand(), 8'(8'hA0 + i));
        end
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
        cycle(1'b0, 1'b1, 1'b1, 30'd12345, 30'd67890, 8'hC3);
        drain();
        check("post_reset_seen", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
